mac_cluster_ctrl: RTL and testbench



---
 rtl/mac_cluster_ctrl_pkg.sv | 24 ++
 rtl/mac_cluster_ctrl_cfg_loader.sv | 53 +++++
 rtl/mac_cluster_ctrl.sv | 153 +++++++++++++++
 tb/tb_mac_cluster_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_cluster_ctrl_pkg.sv
// Shared constants for the MAC quad-cluster job sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mac_cluster_ctrl_pkg;

   // Default drain depth of the attached cluster pipeline.
   localparam int MAC_LAT_DEFAULT = 2;

   // Sequencer state encoding, kept as plain constants so that older
   // blocks and waveform scripts can decode the state register directly.
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_CSET  = 3'd1;
   localparam logic [STATE_W-1:0] ST_RUN   = 3'd2;
   localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
   localparam logic [STATE_W-1:0] ST_CAPT  = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

   // Number of host chunks needed to cover a cfg word of the given width.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/mac_cluster_ctrl_cfg_loader.sv
// Assembles the wide cluster cfg word from narrow host chunks into a shadow register.
// Latency: a chunk accepted on an edge is visible on shadow right after that edge.
// Backpressure: none internally; the parent decides when a chunk fires.
module mac_cluster_ctrl_cfg_loader #(
   parameter int CFG_WIDTH   = 131,
   parameter int CHUNK_WIDTH = 32,
   parameter int NCHUNK      = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   chunk_fire,
   input  logic [CHUNK_WIDTH-1:0] chunk,
   output logic [CFG_WIDTH-1:0]   shadow,
   output logic                   cfg_loaded
);

   localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int PAD_W = NCHUNK * CHUNK_WIDTH;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

   logic [IDX_W-1:0] idx;
   logic [PAD_W-1:0] wr_word;

   // Overlay the incoming chunk on a chunk-aligned copy of the shadow word.
   always_comb begin
      wr_word = PAD_W'(shadow);
      wr_word[idx*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk;
   end

   // Last-chunk bits above the cfg word are dropped on purpose.
   if (PAD_W > CFG_WIDTH) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^wr_word[PAD_W-1:CFG_WIDTH];
   end

   // Chunk index walks 0..NCHUNK-1; chunk 0 invalidates, the last chunk validates.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         shadow     <= '0;
         cfg_loaded <= 1'b0;
      end else if (chunk_fire) begin
         shadow <= wr_word[CFG_WIDTH-1:0];
         idx    <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (idx == IDX_LAST) begin
            cfg_loaded <= 1'b1;
         end else if (idx == '0) begin
            cfg_loaded <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mac_cluster_ctrl.sv
// Job sequencer for one MAC quad-cluster: cfg load, cset pulse, operand streaming, drain, result hold.
// Latency: start -> res_valid is 1 (cset) + beat cycles + (MAC_LAT-1) drain + 1 capture edges.
// Backpressure: op_ready high only while streaming; results held until res_ready; chunks/start ignored while busy.
module mac_cluster_ctrl
   import mac_cluster_ctrl_pkg::*;
#(
   parameter int MAC_CONF_WIDTH = 3,
   parameter int MAC_MIN_WIDTH  = 8,
   parameter int MAC_ACC_WIDTH  = 32,
   parameter int CFG_WIDTH      = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH,
   parameter int CHUNK_WIDTH    = 32,
   parameter int NCHUNK         = ceil_div(CFG_WIDTH, CHUNK_WIDTH),
   parameter int LEN_WIDTH      = 16,
   parameter int MAC_LAT        = MAC_LAT_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_chunk_valid,
   output logic                       cfg_chunk_ready,
   input  logic [CHUNK_WIDTH-1:0]     cfg_chunk,
   input  logic                       start,
   input  logic [LEN_WIDTH-1:0]       len,
   output logic                       busy,
   input  logic                       op_valid,
   output logic                       op_ready,
   input  logic [4*MAC_MIN_WIDTH-1:0] op_a,
   input  logic [4*MAC_MIN_WIDTH-1:0] op_b,
   output logic                       mac_en,
   output logic                       mac_cset,
   output logic [CFG_WIDTH-1:0]       mac_cfg,
   output logic [4*MAC_MIN_WIDTH-1:0] mac_a,
   output logic [4*MAC_MIN_WIDTH-1:0] mac_b,
   input  logic [4*MAC_ACC_WIDTH-1:0] mac_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [4*MAC_ACC_WIDTH-1:0] res_data
);

   // Drain counter counts 0..MAC_LAT-2; with MAC_LAT=1 the drain state is skipped.
   localparam int DRN_W = (MAC_LAT > 2) ? $clog2(MAC_LAT - 1) : 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((MAC_LAT > 1) ? (MAC_LAT - 2) : 0);
   localparam logic [STATE_W-1:0] ST_AFTER_RUN = (MAC_LAT > 1) ? ST_DRAIN : ST_CAPT;

   logic [STATE_W-1:0]   state;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic [DRN_W-1:0]     drn_cnt;
   logic                 cfg_loaded;
   logic                 chunk_fire;
   logic                 start_go;
   logic                 op_fire;
   logic                 last_beat;

   assign chunk_fire = cfg_chunk_valid && cfg_chunk_ready;
   assign start_go   = (state == ST_IDLE) && start && cfg_loaded;
   assign op_fire    = op_valid && op_ready;
   // len_q is nonzero whenever RUN is reached, so len_q-1 cannot wrap here.
   assign last_beat  = (beat_cnt == (len_q - 1'b1));
   assign busy       = (state != ST_IDLE);

   mac_cluster_ctrl_cfg_loader #(
      .CFG_WIDTH   (CFG_WIDTH),
      .CHUNK_WIDTH (CHUNK_WIDTH),
      .NCHUNK      (NCHUNK)
   ) u_cfg_loader (
      .clk        (clk),
      .rst        (rst),
      .chunk_fire (chunk_fire),
      .chunk      (cfg_chunk),
      .shadow     (mac_cfg),
      .cfg_loaded (cfg_loaded)
   );

   // Job sequencing: latch len, pulse cset, count beats, drain, capture, hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         len_q    <= '0;
         beat_cnt <= '0;
         drn_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_go) begin
                  len_q <= len;
                  state <= ST_CSET;
               end
            end
            ST_CSET: begin
               beat_cnt <= '0;
               drn_cnt  <= '0;
               state    <= (len_q != '0) ? ST_RUN : ST_AFTER_RUN;
            end
            ST_RUN: begin
               if (op_fire) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     state <= ST_AFTER_RUN;
                  end
               end
            end
            ST_DRAIN: begin
               if (drn_cnt == DRN_LAST) begin
                  state <= ST_CAPT;
               end else begin
                  drn_cnt <= drn_cnt + 1'b1;
               end
            end
            ST_CAPT: state <= ST_DONE;
            ST_DONE: begin
               if (res_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Lane results are sampled once, after the pipeline has fully drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data <= '0;
      end else if (state == ST_CAPT) begin
         res_data <= mac_out;
      end
   end

   // Cluster pins and handshakes decoded from state; operands pass through only while streaming.
   always_comb begin
      cfg_chunk_ready = 1'b0;
      op_ready        = 1'b0;
      mac_en          = 1'b0;
      mac_cset        = 1'b0;
      mac_a           = '0;
      mac_b           = '0;
      res_valid       = 1'b0;
      case (state)
         ST_IDLE:  cfg_chunk_ready = !start;
         ST_CSET:  mac_cset = 1'b1;
         ST_RUN: begin
            op_ready = 1'b1;
            mac_en   = op_valid;
            mac_a    = op_a;
            mac_b    = op_b;
         end
         ST_DRAIN: mac_en = 1'b1;
         ST_DONE:  res_valid = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_mac_cluster_ctrl.sv
// Self-checking bench for mac_cluster_ctrl with a two-stage MAC cluster model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mac_cluster_ctrl;

   localparam int CONF_W  = 3;
   localparam int MIN_W   = 8;
   localparam int ACC_W   = 32;
   localparam int CFG_W   = 4*ACC_W + CONF_W;
   localparam int CHUNK_W = 32;
   localparam int NCH     = 5;
   localparam int PAD_W   = NCH*CHUNK_W;
   localparam int LEN_W   = 16;
   localparam int LAT     = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cfg_chunk_valid;
   logic                 cfg_chunk_ready;
   logic [CHUNK_W-1:0]   cfg_chunk;
   logic                 start;
   logic [LEN_W-1:0]     len;
   logic                 busy;
   logic                 op_valid;
   logic                 op_ready;
   logic [4*MIN_W-1:0]   op_a, op_b;
   logic                 mac_en, mac_cset;
   logic [CFG_W-1:0]     mac_cfg;
   logic [4*MIN_W-1:0]   mac_a, mac_b;
   logic [4*ACC_W-1:0]   mac_out;
   logic                 res_valid, res_ready;
   logic [4*ACC_W-1:0]   res_data;

   mac_cluster_ctrl #(
      .MAC_CONF_WIDTH (CONF_W), .MAC_MIN_WIDTH (MIN_W), .MAC_ACC_WIDTH (ACC_W),
      .CFG_WIDTH (CFG_W), .CHUNK_WIDTH (CHUNK_W), .NCHUNK (NCH),
      .LEN_WIDTH (LEN_W), .MAC_LAT (LAT)
   ) dut (
      .clk (clk), .rst (rst),
      .cfg_chunk_valid (cfg_chunk_valid), .cfg_chunk_ready (cfg_chunk_ready), .cfg_chunk (cfg_chunk),
      .start (start), .len (len), .busy (busy),
      .op_valid (op_valid), .op_ready (op_ready), .op_a (op_a), .op_b (op_b),
      .mac_en (mac_en), .mac_cset (mac_cset), .mac_cfg (mac_cfg), .mac_a (mac_a), .mac_b (mac_b),
      .mac_out (mac_out),
      .res_valid (res_valid), .res_ready (res_ready), .res_data (res_data)
   );

   always #5 clk = ~clk;

   // Cluster model: product register then accumulator, both advancing on en (two en edges to output).
   logic [ACC_W-1:0] cl_acc [4];
   logic [ACC_W-1:0] cl_prod[4];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mac_cset) begin
            cl_acc[i]  <= mac_cfg[CONF_W + i*ACC_W +: ACC_W];
            cl_prod[i] <= '0;
         end else if (mac_en) begin
            cl_prod[i] <= ACC_W'(mac_a[i*MIN_W +: MIN_W]) * ACC_W'(mac_b[i*MIN_W +: MIN_W]);
            cl_acc[i]  <= mac_cfg[CONF_W-1] ? cl_acc[i] + cl_prod[i] : cl_prod[i];
         end
      end
   end
   assign mac_out = {cl_acc[3], cl_acc[2], cl_acc[1], cl_acc[0]};

   // Edge-level monitor: activity counters and pin-rule violations.
   int cyc = 0, mon_en = 0, mon_cset = 0, mon_hs = 0, mon_opr = 0, mon_err = 0, cset_cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (mac_en)   mon_en   <= mon_en + 1;
         if (op_ready) mon_opr  <= mon_opr + 1;
         if (op_valid && op_ready) mon_hs <= mon_hs + 1;
         if (mac_cset) begin
            mon_cset <= mon_cset + 1;
            cset_cyc <= cyc + 1;
         end
         if (op_ready) begin
            if (mac_en !== op_valid || mac_a !== op_a || mac_b !== op_b) mon_err <= mon_err + 1;
         end else if (mac_a !== '0 || mac_b !== '0 || ((!busy || res_valid || mac_cset) && mac_en)) begin
            mon_err <= mon_err + 1;
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [4*MIN_W-1:0] beat_a[$], beat_b[$];
   logic [CFG_W-1:0]   cur_cfg;

   // Results of the last job run by do_job.
   logic [4*ACC_W-1:0] j_got;
   int j_t0, j_tot, j_lat, j_hs, j_en, j_cset, j_opr, j_err, j_hold;
   bit j_to;

   // Reference: each lane starts at its init field and accumulates a*b over all beats.
   function automatic logic [4*ACC_W-1:0] ref_result(input logic [CFG_W-1:0] cfg);
      logic [4*ACC_W-1:0] r;
      for (int l = 0; l < 4; l++) begin
         logic [ACC_W-1:0] acc;
         acc = cfg[CONF_W + l*ACC_W +: ACC_W];
         foreach (beat_a[k])
            acc = acc + ACC_W'(beat_a[k][l*MIN_W +: MIN_W]) * ACC_W'(beat_b[k][l*MIN_W +: MIN_W]);
         r[l*ACC_W +: ACC_W] = acc;
      end
      return r;
   endfunction

   task automatic load_chunks(input logic [PAD_W-1:0] pad, output int nacc);
      nacc = 0;
      for (int k = 0; k < NCH; k++) begin
         @(posedge clk); #1;
         cfg_chunk_valid = 1'b1;
         cfg_chunk = pad[k*CHUNK_W +: CHUNK_W];
         #1;
         if (cfg_chunk_ready) nacc++;
      end
      @(posedge clk); #1;
      cfg_chunk_valid = 1'b0;
      cur_cfg = pad[CFG_W-1:0];
   endtask

   // Runs one job with the beats in beat_a/beat_b; vpct<0 alternates op_valid.
   task automatic do_job(input int vpct, input int rdy_wait, input bit poke);
      int n, i, t_last, guard, e0, h0, c0, o0, r0;
      bit hs, phase;
      logic [CFG_W-1:0] cfg0;
      n = beat_a.size();
      e0 = mon_en; h0 = mon_hs; c0 = mon_cset; o0 = mon_opr; r0 = mon_err;
      j_to = 1'b0; j_hold = 0; j_got = '0;
      @(posedge clk); #1;
      start = 1'b1; len = LEN_W'(n);
      @(posedge clk); #1;
      j_t0 = cyc; t_last = cyc + 1;
      start = 1'b0; len = LEN_W'($urandom);
      i = 0; guard = 0; phase = 1'b0;
      while (res_valid !== 1'b1 && guard < 200 + 4*n) begin
         op_valid = (vpct < 0) ? phase : (int'($urandom_range(99)) < vpct);
         phase = !phase;
         if (i < n) begin op_a = beat_a[i]; op_b = beat_b[i]; end
         else begin op_a = $urandom; op_b = $urandom; end
         #1;
         hs = op_valid && op_ready;
         @(posedge clk); #1;
         if (hs) begin i++; t_last = cyc; end
         guard++;
      end
      op_valid = 1'b0;
      j_to  = (res_valid !== 1'b1);
      j_tot = cyc - j_t0;
      j_lat = cyc - t_last;
      if (!j_to) begin
         j_got = res_data;
         cfg0  = mac_cfg;
         for (int k = 0; k < rdy_wait; k++) begin
            if (poke) begin
               start = 1'b1; len = LEN_W'($urandom);
               cfg_chunk_valid = 1'b1; cfg_chunk = $urandom;
               op_valid = 1'b1;
            end
            #1;
            if (res_data !== j_got || res_valid !== 1'b1 || op_ready !== 1'b0 ||
                cfg_chunk_ready !== 1'b0 || mac_cfg !== cfg0 || busy !== 1'b1) j_hold++;
            @(posedge clk); #1;
         end
         if (res_data !== j_got || mac_cfg !== cfg0) j_hold++;
         res_ready = 1'b1;
         @(posedge clk); #1;
         res_ready = 1'b0; start = 1'b0; cfg_chunk_valid = 1'b0; op_valid = 1'b0;
         if (res_valid !== 1'b0 || busy !== 1'b0) j_hold++;
      end
      j_en = mon_en - e0; j_hs = mon_hs - h0; j_cset = mon_cset - c0;
      j_opr = mon_opr - o0; j_err = mon_err - r0;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0b required 0", res_valid); end
      n_checks++; if ({mac_en, mac_cset, op_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %03b required 000", {mac_en, mac_cset, op_ready}); end
      n_checks++; if (mac_cfg !== '0) begin n_fail++; $display("FAIL reset_cfg: got %h required 0", mac_cfg); end
      n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data: got %h required 0", res_data); end
      n_checks++; if (cfg_chunk_ready !== 1'b1) begin n_fail++; $display("FAIL reset_chunk_ready: got %0b required 1", cfg_chunk_ready); end
      // No cfg loaded yet: start must be ignored.
      bad = 0;
      start = 1'b1; len = 16'd3;
      #1;
      n_checks++; if (cfg_chunk_ready !== 1'b0) begin n_fail++; $display("FAIL chunk_ready_with_start: got %0b required 0", cfg_chunk_ready); end
      repeat (4) begin @(posedge clk); #1; if (busy !== 1'b0) bad++; end
      start = 1'b0;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL start_without_cfg: busy cycles %0d required 0", bad); end
   endtask

   task automatic test_cfg_load();
      logic [PAD_W-1:0] pad;
      logic [2:0] mode;
      logic [4*ACC_W-1:0] exp_r;
      int nacc;
      pad = {32'h4, 32'h3, 32'h2, 32'h1, 32'h0000_0004};
      load_chunks(pad, nacc);
      mode = mac_cfg[2:0];
      n_checks++; if (nacc !== NCH) begin n_fail++; $display("FAIL chunk_accepts: got %0d required %0d", nacc, NCH); end
      n_checks++; if (mac_cfg !== pad[CFG_W-1:0]) begin n_fail++; $display("FAIL cfg_assembly: got %h required %h", mac_cfg, pad[CFG_W-1:0]); end
      n_checks++; if (mode !== 3'b100) begin n_fail++; $display("FAIL cfg_mode: got %03b required 100", mode); end
      // len=0 job: cset, one drain cycle, capture; result is the init value.
      beat_a.delete(); beat_b.delete();
      exp_r = ref_result(cur_cfg);
      do_job(100, 0, 1'b0);
      n_checks++; if (j_to) begin n_fail++; $display("FAIL len0_timeout: res_valid never rose"); end
      n_checks++; if (j_cset !== 1) begin n_fail++; $display("FAIL len0_cset_count: got %0d required 1", j_cset); end
      n_checks++; if (cset_cyc !== j_t0 + 1) begin n_fail++; $display("FAIL cset_timing: edge %0d required %0d", cset_cyc, j_t0 + 1); end
      n_checks++; if (j_opr !== 0) begin n_fail++; $display("FAIL len0_op_ready: got %0d cycles required 0", j_opr); end
      n_checks++; if (j_tot !== 1 + LAT) begin n_fail++; $display("FAIL len0_latency: got %0d required %0d", j_tot, 1 + LAT); end
      n_checks++; if (j_en !== LAT - 1) begin n_fail++; $display("FAIL len0_en_cycles: got %0d required %0d", j_en, LAT - 1); end
      n_checks++; if (j_got !== exp_r) begin n_fail++; $display("FAIL len0_result: got %h required %h", j_got, exp_r); end
   endtask

   task automatic test_mac_full(input int vpct, input string tag);
      logic [PAD_W-1:0] pad;
      int nacc;
      pad = '0; pad[2:0] = 3'b100;
      load_chunks(pad, nacc);
      beat_a.delete(); beat_b.delete();
      for (int k = 1; k <= 4; k++) begin
         beat_a.push_back({4{8'(k)}});
         beat_b.push_back(32'h0202_0202);
      end
      do_job(vpct, 2, 1'b0);
      n_checks++; if (j_to) begin n_fail++; $display("FAIL %s_timeout: res_valid never rose", tag); end
      n_checks++; if (j_got !== {4{32'd20}}) begin n_fail++; $display("FAIL %s_result: got %h required 20 per lane", tag, j_got); end
      n_checks++; if (j_hs !== 4) begin n_fail++; $display("FAIL %s_handshakes: got %0d required 4", tag, j_hs); end
      n_checks++; if (j_en !== 5) begin n_fail++; $display("FAIL %s_en_cycles: got %0d required 5", tag, j_en); end
      n_checks++; if (j_err !== 0) begin n_fail++; $display("FAIL %s_pin_rules: got %0d violations required 0", tag, j_err); end
      if (vpct == 100) begin
         n_checks++; if (j_tot !== 7) begin n_fail++; $display("FAIL %s_latency: got %0d edges required 7", tag, j_tot); end
      end
   endtask

   task automatic test_hold_done();
      logic [4*ACC_W-1:0] exp_r;
      beat_a.delete(); beat_b.delete();
      repeat (3) begin beat_a.push_back($urandom); beat_b.push_back($urandom); end
      exp_r = ref_result(cur_cfg);
      do_job(80, 10, 1'b1);
      n_checks++; if (j_to) begin n_fail++; $display("FAIL hold_timeout: res_valid never rose"); end
      n_checks++; if (j_hold !== 0) begin n_fail++; $display("FAIL hold_done: got %0d violations required 0", j_hold); end
      n_checks++; if (j_got !== exp_r) begin n_fail++; $display("FAIL hold_result: got %h required %h", j_got, exp_r); end
   endtask

   task automatic test_reset_mid_run();
      logic [PAD_W-1:0] pad;
      logic [4*ACC_W-1:0] exp_r;
      int nacc, bad;
      @(posedge clk); #1; start = 1'b1; len = 16'd6;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; op_valid = 1'b1; op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b1 || op_ready !== 1'b1) begin n_fail++; $display("FAIL mid_run_active: busy %0b op_ready %0b required 1 1", busy, op_ready); end
      rst = 1'b1; op_valid = 1'b0;
      @(posedge clk); #1; rst = 1'b0; #1;
      n_checks++; if ({busy, mac_en, res_valid, op_ready} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ctrl: got %04b required 0000", {busy, mac_en, res_valid, op_ready}); end
      n_checks++; if (mac_cfg !== '0) begin n_fail++; $display("FAIL mid_reset_cfg: got %h required 0", mac_cfg); end
      bad = 0;
      start = 1'b1; len = 16'd2;
      repeat (4) begin @(posedge clk); #1; if (busy !== 1'b0) bad++; end
      start = 1'b0;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL start_after_reset: busy cycles %0d required 0", bad); end
      for (int w = 0; w < NCH; w++) pad[w*CHUNK_W +: CHUNK_W] = $urandom;
      pad[CONF_W-1] = 1'b1;
      load_chunks(pad, nacc);
      beat_a.delete(); beat_b.delete();
      repeat (3) begin beat_a.push_back($urandom); beat_b.push_back($urandom); end
      exp_r = ref_result(cur_cfg);
      do_job(100, 1, 1'b0);
      n_checks++; if (j_to || j_got !== exp_r) begin n_fail++; $display("FAIL after_reload_result: got %h required %h timeout %0b", j_got, exp_r, j_to); end
   endtask

   task automatic test_random();
      logic [PAD_W-1:0] pad;
      logic [4*ACC_W-1:0] exp_r;
      int nacc, n;
      for (int j = 0; j < 25; j++) begin
         if ($urandom_range(1) == 1) begin
            for (int w = 0; w < NCH; w++) pad[w*CHUNK_W +: CHUNK_W] = $urandom;
            pad[CONF_W-1] = 1'b1;
            load_chunks(pad, nacc);
         end
         n = int'($urandom_range(12, 1));
         beat_a.delete(); beat_b.delete();
         repeat (n) begin beat_a.push_back($urandom); beat_b.push_back($urandom); end
         exp_r = ref_result(cur_cfg);
         do_job(int'($urandom_range(100, 30)), int'($urandom_range(3)), 1'b0);
         n_checks++; if (j_to) begin n_fail++; $display("FAIL rand%0d_timeout: res_valid never rose", j); end
         n_checks++; if (j_got !== exp_r) begin n_fail++; $display("FAIL rand%0d_result: got %h required %h", j, j_got, exp_r); end
         n_checks++; if (j_hs !== n) begin n_fail++; $display("FAIL rand%0d_handshakes: got %0d required %0d", j, j_hs, n); end
         n_checks++; if (j_en !== n + LAT - 1) begin n_fail++; $display("FAIL rand%0d_en_cycles: got %0d required %0d", j, j_en, n + LAT - 1); end
         n_checks++; if (j_lat !== LAT) begin n_fail++; $display("FAIL rand%0d_drain_latency: got %0d required %0d", j, j_lat, LAT); end
         n_checks++; if (j_cset !== 1 || j_err !== 0 || j_hold !== 0) begin n_fail++; $display("FAIL rand%0d_protocol: cset %0d pin_err %0d hold_err %0d required 1 0 0", j, j_cset, j_err, j_hold); end
      end
   endtask

   // Two jobs on one cfg load: each must restart from the init values.
   task automatic test_back_to_back();
      logic [4*ACC_W-1:0] exp_r;
      for (int j = 0; j < 2; j++) begin
         beat_a.delete(); beat_b.delete();
         repeat (5) begin beat_a.push_back($urandom); beat_b.push_back($urandom); end
         exp_r = ref_result(cur_cfg);
         do_job(100, 0, 1'b0);
         n_checks++; if (j_to || j_got !== exp_r) begin n_fail++; $display("FAIL b2b%0d_result: got %h required %h timeout %0b", j, j_got, exp_r, j_to); end
         n_checks++; if (j_cset !== 1) begin n_fail++; $display("FAIL b2b%0d_cset: got %0d required 1", j, j_cset); end
      end
   endtask

   initial begin
      rst = 1'b1; cfg_chunk_valid = 1'b0; cfg_chunk = '0; start = 1'b0; len = '0;
      op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0; cur_cfg = '0;
      test_reset();
      test_cfg_load();
      test_mac_full(100, "mac_full");
      test_mac_full(-1, "mac_toggle");
      test_hold_done();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
